// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between the
// instruction-fetch requester (I) and the data requester (D). One access is in
// flight at a time: IDLE arbitrates and latches, ISSUE strobes the memory, WAIT
// covers the remaining read latency, RESP returns a single pulse to the owner.
module mem_port_arbiter #(
    parameter int unsigned PRIO_MODE  = 0,  // 0: D-priority + starvation guard, 1: round-robin
    parameter int unsigned STARVE_MAX = 4,  // 1..15
    parameter int unsigned MEM_LAT    = 1   // 1..4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    // memory macro
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    // status
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam int unsigned LoseW = 4;
    localparam int unsigned CntW  = 2;

    localparam logic [LoseW-1:0] StarveMax = LoseW'(STARVE_MAX);
    localparam logic [CntW-1:0]  LatM1     = CntW'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_d_q, owner_d_d;  // 1: D owns the access, 0: I
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LoseW-1:0]  lose_q, lose_d;
    logic              last_d_q, last_d_d;    // 1: last grant went to D
    logic [31:0]       i_hold_q, i_hold_d;
    logic [31:0]       d_hold_q, d_hold_d;

    logic              grant_d;
    logic              both_req;

    assign both_req = i_req & d_req;

    // Arbitration decision, only meaningful while in IDLE with a request present.
    always_comb begin
        grant_d = 1'b0;
        if (both_req) begin
            if (PRIO_MODE == 0) begin
                // D wins unless I has lost STARVE_MAX contested rounds in a row
                grant_d = (lose_q != StarveMax);
            end else begin
                grant_d = ~last_d_q;
            end
        end else begin
            grant_d = d_req;
        end
    end

    // Next-state logic, latches and output decode.
    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        lose_d    = lose_q;
        last_d_d  = last_d_q;
        i_hold_d  = i_hold_q;
        d_hold_d  = d_hold_q;

        mem_en    = 1'b0;
        mem_we    = 4'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        i_rvalid  = 1'b0;
        d_done    = 1'b0;
        i_rdata   = i_hold_q;
        d_rdata   = d_hold_q;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d_d = grant_d;
                    we_d      = d_we;
                    addr_d    = grant_d ? d_addr : i_addr;
                    wdata_d   = d_wdata;
                    wstrb_d   = d_wstrb;
                    last_d_d  = grant_d;
                    if (!grant_d) begin
                        lose_d = '0;
                    end else if (i_req && (lose_q != StarveMax)) begin
                        lose_d = lose_q + 4'd1;
                    end
                    state_d = StIssue;
                end
            end

            StIssue: begin
                mem_en    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = (owner_d_q && we_q) ? wstrb_q : 4'b0;
                cnt_d     = LatM1;
                state_d   = (MEM_LAT > 1) ? StWait : StResp;
            end

            StWait: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = StResp;
                end
            end

            StResp: begin
                if (owner_d_q) begin
                    d_done = 1'b1;
                    if (!we_q) begin
                        d_rdata  = mem_rdata;
                        d_hold_d = mem_rdata;
                    end
                end else begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                    i_hold_d = mem_rdata;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latch registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            wstrb_q   <= 4'b0;
            cnt_q     <= '0;
            lose_q    <= '0;
            last_d_q  <= 1'b1;
            i_hold_q  <= 32'b0;
            d_hold_q  <= 32'b0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            lose_q    <= lose_d;
            last_d_q  <= last_d_d;
            i_hold_q  <= i_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (0: D-priority, MEM_LAT=3;
// 1: round-robin, MEM_LAT=1) driven by random requesters. A reference model
// predicts every grant and pushes the expected access into a per-instance
// queue; a monitor process checks the memory port and response pulses.
module tb_mem_port_arbiter;

    localparam int NI     = 2;
    localparam int STARVE = 4;
    localparam int LAT0   = 3;
    localparam int LAT1   = 1;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          issue_cyc;
        int          resp_cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req     [NI];
    logic [31:0] i_addr    [NI];
    logic        i_rvalid  [NI];
    logic [31:0] i_rdata   [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [31:0] d_addr    [NI];
    logic [31:0] d_wdata   [NI];
    logic [3:0]  d_wstrb   [NI];
    logic        d_done    [NI];
    logic [31:0] d_rdata   [NI];
    logic        mem_en    [NI];
    logic [3:0]  mem_we    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];

    int   cyc = 0;
    txn_t exp_q [NI][$];
    bit   done = 1'b0;
    bit   rst_hit = 1'b0;

    function automatic logic [31:0] init_word(int k);
        if (k == 16) return 32'h2402_0005;
        if (k == 128) return 32'h1234_5678;
        return 32'h5A00_0000 ^ (k * 32'h0001_0203);
    endfunction

    function automatic int lat_of(int g);
        return (g == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 99));
    endfunction

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? LAT0 : LAT1;

        logic [31:0] macro  [256];
        logic [31:0] pipe_d [4];
        logic        pipe_v [4];
        logic [31:0] junk;

        mem_port_arbiter #(
            .PRIO_MODE (g),
            .STARVE_MAX(STARVE),
            .MEM_LAT   (L)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_req    (i_req[g]),
            .i_addr   (i_addr[g]),
            .i_rvalid (i_rvalid[g]),
            .i_rdata  (i_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_wstrb  (d_wstrb[g]),
            .d_done   (d_done[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );

        // Memory macro: read data valid L cycles after mem_en, junk otherwise.
        always @(posedge clk) begin
            junk <= $urandom;
            if (rst) begin
                for (int k = 0; k < 256; k++) macro[k] <= init_word(k);
                for (int k = 0; k < 4; k++) pipe_v[k] <= 1'b0;
            end else begin
                if (mem_en[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_we[g][b]) macro[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                    end
                end
                pipe_v[0] <= mem_en[g];
                pipe_d[0] <= macro[mem_addr[g][9:2]];
                for (int k = 1; k < 4; k++) begin
                    pipe_v[k] <= pipe_v[k-1];
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end

        assign mem_rdata[g] = pipe_v[L-1] ? pipe_d[L-1] : junk;
    end

    // ---------------- reference model and stimulus ----------------
    int          free_at   [NI];
    int          lose      [NI];
    bit          last_d    [NI];
    bit          i_pend    [NI];
    bit          d_pend    [NI];
    bit          i_gnt     [NI];
    bit          d_gnt     [NI];
    int          i_iss_at  [NI];
    int          d_iss_at  [NI];
    int          i_resp_at [NI];
    int          d_resp_at [NI];
    bit          first_i   [NI];
    logic [31:0] mmem      [NI][256];

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            lose[g] = 0;
            last_d[g] = 1'b1;
            i_pend[g] = 1'b0;
            d_pend[g] = 1'b0;
            i_gnt[g] = 1'b0;
            d_gnt[g] = 1'b0;
            i_req[g] = 1'b0;
            d_req[g] = 1'b0;
            i_addr[g] = 32'b0;
            d_we[g] = 1'b0;
            d_addr[g] = 32'b0;
            d_wdata[g] = 32'b0;
            d_wstrb[g] = 4'b0;
            for (int k = 0; k < 256; k++) mmem[g][k] = init_word(k);
        end
    endtask

    task automatic do_reset(int hold);
        rst = 1'b1;
        model_reset();
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) free_at[g] = cyc;
    endtask

    task automatic grant(int g, int k);
        txn_t t;
        bit   both;
        bit   gd;
        int   idx;
        both = i_req[g] && d_req[g];
        if (!both) gd = d_req[g];
        else if (g == 0) gd = (lose[g] != STARVE);
        else gd = !last_d[g];
        if (g == 0) begin
            if (!gd) lose[g] = 0;
            else if (both) lose[g] = (lose[g] < STARVE) ? lose[g] + 1 : STARVE;
        end
        last_d[g] = gd;
        t.is_d = gd;
        t.we = d_we[g];
        t.addr = gd ? d_addr[g] : i_addr[g];
        t.wdata = d_wdata[g];
        t.wstrb = d_wstrb[g];
        t.issue_cyc = k + 1;
        t.resp_cyc = k + 1 + lat_of(g);
        idx = int'(t.addr[9:2]);
        t.rdata = mmem[g][idx];
        if (gd && t.we) begin
            for (int b = 0; b < 4; b++) begin
                if (t.wstrb[b]) mmem[g][idx][8*b +: 8] = t.wdata[8*b +: 8];
            end
        end
        exp_q[g].push_back(t);
        free_at[g] = k + lat_of(g) + 2;
        if (gd) begin
            d_gnt[g] = 1'b1;
            d_iss_at[g] = t.issue_cyc;
            d_resp_at[g] = t.resp_cyc;
        end else begin
            i_gnt[g] = 1'b1;
            i_iss_at[g] = t.issue_cyc;
            i_resp_at[g] = t.resp_cyc;
        end
    endtask

    // One negedge worth of requester behaviour plus model arbitration.
    task automatic step(int p_i, int p_d, int wd, int drop);
        for (int g = 0; g < NI; g++) begin
            int k;
            k = cyc;
            if (i_gnt[g] && k == i_resp_at[g]) begin
                i_gnt[g] = 1'b0; i_pend[g] = 1'b0; i_req[g] = 1'b0;
            end
            if (d_gnt[g] && k == d_resp_at[g]) begin
                d_gnt[g] = 1'b0; d_pend[g] = 1'b0; d_req[g] = 1'b0;
            end
            // once latched, the bus may wander and the request may even drop
            if (i_gnt[g] && k >= i_iss_at[g]) begin
                i_addr[g] = $urandom;
                if (rnd() < drop) i_req[g] = 1'b0;
            end
            if (d_gnt[g] && k >= d_iss_at[g]) begin
                d_addr[g] = $urandom; d_wdata[g] = $urandom;
                d_we[g] = 1'($urandom); d_wstrb[g] = 4'($urandom);
                if (rnd() < drop) d_req[g] = 1'b0;
            end
            if (i_pend[g] && !i_gnt[g] && rnd() < wd) begin
                i_pend[g] = 1'b0; i_req[g] = 1'b0;
            end
            if (d_pend[g] && !d_gnt[g] && rnd() < wd) begin
                d_pend[g] = 1'b0; d_req[g] = 1'b0;
            end
            if (!i_pend[g] && rnd() < p_i) begin
                i_pend[g] = 1'b1;
                i_req[g] = 1'b1;
                i_addr[g] = first_i[g] ? 32'h0000_0040 : $urandom;
                first_i[g] = 1'b0;
            end
            if (!d_pend[g] && rnd() < p_d) begin
                d_pend[g] = 1'b1;
                d_req[g] = 1'b1;
                d_we[g] = 1'($urandom);
                d_addr[g] = $urandom;
                d_wdata[g] = $urandom;
                d_wstrb[g] = (rnd() < 15) ? 4'b0 : 4'($urandom);
            end
            if (k >= free_at[g] && (i_req[g] || d_req[g])) grant(g, k);
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) first_i[g] = 1'b1;
        do_reset(3);
        // both requesters held continuously
        for (int n = 0; n < 70; n++) begin
            step(100, 100, 0, 0);
            @(negedge clk);
        end
        for (int n = 0; n < 1500; n++) begin
            step(40, 40, 10, 10);
            @(negedge clk);
        end
        // reset while instance 0 sits in WAIT
        for (int n = 0; n < 400 && !rst_hit; n++) begin
            if (exp_q[0].size() > 0 && cyc > exp_q[0][0].issue_cyc &&
                cyc < exp_q[0][0].resp_cyc) begin
                do_reset(2);
                rst_hit = 1'b1;
            end else begin
                step(40, 40, 10, 10);
            end
            @(negedge clk);
        end
        for (int n = 0; n < 500; n++) begin
            step(50, 30, 10, 10);
            @(negedge clk);
        end
        for (int n = 0; n < 40; n++) begin
            step(0, 0, 0, 0);
            @(negedge clk);
        end
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] hold_i [NI];
    logic [31:0] hold_d [NI];
    logic [9:0]  gseq   [NI];
    int          gcnt   [NI];
    int          served [NI];

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %h, want %h", name, g, cyc, act, exp);
        end
    endtask

    initial begin
        txn_t h;
        bit   has, exp_en, pulse_i, pulse_d;
        for (int g = 0; g < NI; g++) begin
            hold_i[g] = 32'b0; hold_d[g] = 32'b0;
            gseq[g] = 10'b0; gcnt[g] = 0; served[g] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (done) break;
            for (int g = 0; g < NI; g++) begin
                if (rst) begin
                    chk("rst_ctrl", g, {28'b0, i_rvalid[g], d_done[g], mem_en[g], busy[g]}, 32'b0);
                    chk("rst_mem_we", g, 32'(mem_we[g]), 32'b0);
                    chk("rst_mem_addr", g, mem_addr[g], 32'b0);
                    chk("rst_mem_wdata", g, mem_wdata[g], 32'b0);
                    chk("rst_i_rdata", g, i_rdata[g], 32'b0);
                    chk("rst_d_rdata", g, d_rdata[g], 32'b0);
                    hold_i[g] = 32'b0;
                    hold_d[g] = 32'b0;
                    exp_q[g].delete();
                end else begin
                    has = exp_q[g].size() > 0;
                    if (has) h = exp_q[g][0];
                    exp_en = has && h.issue_cyc == cyc;
                    pulse_i = has && h.resp_cyc == cyc && !h.is_d;
                    pulse_d = has && h.resp_cyc == cyc && h.is_d;
                    chk("mem_en", g, 32'(mem_en[g]), 32'(exp_en));
                    chk("mem_addr", g, mem_addr[g], exp_en ? h.addr : 32'b0);
                    chk("mem_wdata", g, mem_wdata[g], exp_en ? h.wdata : 32'b0);
                    chk("mem_we", g, 32'(mem_we[g]),
                        (exp_en && h.is_d && h.we) ? 32'(h.wstrb) : 32'b0);
                    chk("busy", g, 32'(busy[g]), 32'(has && cyc >= h.issue_cyc));
                    chk("i_rvalid", g, 32'(i_rvalid[g]), 32'(pulse_i));
                    chk("d_done", g, 32'(d_done[g]), 32'(pulse_d));
                    chk("i_rdata", g, i_rdata[g], pulse_i ? h.rdata : hold_i[g]);
                    chk("d_rdata", g, d_rdata[g], (pulse_d && !h.we) ? h.rdata : hold_d[g]);
                    if ((i_rvalid[g] || d_done[g]) && gcnt[g] < 10) begin
                        gseq[g] = {gseq[g][8:0], d_done[g]};
                        gcnt[g]++;
                    end
                    if (has && h.resp_cyc == cyc) begin
                        if (pulse_i) hold_i[g] = h.rdata;
                        if (pulse_d && !h.we) hold_d[g] = h.rdata;
                        served[g]++;
                        void'(exp_q[g].pop_front());
                    end
                end
            end
        end
        // D,D,D,D,I,D,D,D,D,I for D-priority; strict I,D alternation for round-robin
        chk("grant_order", 0, 32'(gseq[0]), 32'h0000_03DE);
        chk("grant_order", 1, 32'(gseq[1]), 32'h0000_0155);
        for (int g = 0; g < NI; g++) begin
            chk("drain_empty", g, exp_q[g].size(), 32'b0);
            chk("served_enough", g, 32'(served[g] > 100), 32'd1);
        end
        chk("reset_in_wait", 0, 32'(rst_hit), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
